mont_param_gen: RTL

//  Precomputes the Montgomery parameters for one odd modulus m:
//  - m_size = bit length L of m
//  - r_red  = 2^L mod m, the R-reduction constant used for conversion into the Montgomery domain

---
 rtl/mont_param_gen.sv | 119 +++++++++++
 1 files changed

// File: rtl/mont_param_gen.sv
// Montgomery parameter generator: for an odd modulus m, computes its bit length L
// and the R-reduction constant 2^L mod m using a bit-serial scan/reduce FSM.
module mont_param_gen #(
  parameter int NBITS = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_p,
  input  logic [NBITS-1:0] m,
  output logic [11:0]      m_size,
  output logic [NBITS-1:0] r_red,
  output logic             err,
  output logic             busy,
  output logic             done_irq_p
);

  typedef enum logic [1:0] {IDLE, SCAN, REDUCE, DONE} state_t;

  state_t           state, state_n;
  logic [NBITS-1:0] m_reg, m_reg_n;
  logic [NBITS-1:0] scan, scan_n;
  logic [11:0]      cnt, cnt_n;
  logic [11:0]      len, len_n;
  logic [NBITS:0]   r, r_n;
  logic [NBITS:0]   t;
  logic [11:0]      m_size_n;
  logic [NBITS-1:0] r_red_n;
  logic             err_n, busy_n, done_n;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n  = state;
    m_reg_n  = m_reg;
    scan_n   = scan;
    cnt_n    = cnt;
    len_n    = len;
    r_n      = r;
    m_size_n = m_size;
    r_red_n  = r_red;
    err_n    = err;
    // r < m_reg < 2^NBITS, so doubling always fits in NBITS+1 bits.
    t        = r + r;

    case (state)
      IDLE: begin
        if (enable_p) begin
          if (!m[0]) begin
            err_n    = 1'b1;
            m_size_n = '0;
            r_red_n  = '0;
            state_n  = DONE;
          end else begin
            m_reg_n = m;
            scan_n  = m;
            cnt_n   = '0;
            err_n   = 1'b0;
            state_n = SCAN;
          end
        end
      end
      SCAN: begin
        if (scan != '0) begin
          scan_n = scan >> 1;
          cnt_n  = cnt + 12'd1;
        end else begin
          len_n   = cnt;
          r_n     = (m_reg == {{(NBITS-1){1'b0}}, 1'b1}) ? '0 : {{NBITS{1'b0}}, 1'b1};
          state_n = REDUCE;
        end
      end
      REDUCE: begin
        if (cnt != '0) begin
          r_n   = (t >= {1'b0, m_reg}) ? t - {1'b0, m_reg} : t;
          cnt_n = cnt - 12'd1;
        end else begin
          r_red_n  = r[NBITS-1:0];
          m_size_n = len;
          state_n  = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only; all registers, including the
  // wide datapath, are cleared so a reset mid-operation leaves no stale partial result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      m_reg      <= '0;
      scan       <= '0;
      cnt        <= '0;
      len        <= '0;
      r          <= '0;
      m_size     <= '0;
      r_red      <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
      done_irq_p <= 1'b0;
    end else begin
      state      <= state_n;
      m_reg      <= m_reg_n;
      scan       <= scan_n;
      cnt        <= cnt_n;
      len        <= len_n;
      r          <= r_n;
      m_size     <= m_size_n;
      r_red      <= r_red_n;
      err        <= err_n;
      busy       <= busy_n;
      done_irq_p <= done_n;
    end
  end

endmodule
